// File: rtl/counter_pkg.sv
// Shared encodings for the counter/timer: FSM states and count modes.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_WRAP    = 1'b1
    } mode_t;

endpackage

// File: rtl/counter_timer_if.sv
// Control/status bundle between the game FSM (master) and the counter/timer (slave).
interface counter_timer_if #(
    parameter int WIDTH = 16
) ();
    logic             go;
    logic             stop;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             done;
    logic             busy;

    modport master (
        output go, stop, en, mode,
        input  count, tick, done, busy
    );

    modport slave (
        input  go, stop, en, mode,
        output count, tick, done, busy
    );
endinterface

// File: rtl/clk_enable_div.sv
// Prescaler: turns every PRESCALE-th enabled cycle into a one-cycle step enable.
module clk_enable_div #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic step_en
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] psc;
    logic          last;

    // Step is decided combinationally so the top can act on it in the same edge.
    assign last    = (psc == PW'(PRESCALE - 1));
    assign step_en = en & last;

    // Phase counter: cleared on restart, frozen whenever en is low.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            psc <= '0;
        end else if (en) begin
            psc <= last ? '0 : psc + PW'(1);
        end
    end
endmodule

// File: rtl/counter_timer.sv
// Prescaled up-counter with one-shot/wrap modes, abort, terminal pulse and beat tick.
module counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAXCOUNT = 39648,
    parameter int PRESCALE = 1,
    parameter int TICK_DIV = 1024
) (
    input  logic            clk,
    input  logic            reset,
    counter_timer_if.slave  bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic             tick, tick_nxt;
    logic             done, done_nxt;
    logic             busy;
    logic             div_clr, div_en, step_en;

    // The prescaler only advances in RUN on a cycle not overridden by stop or go.
    assign div_clr = bus.go & ~bus.stop;
    assign div_en  = (state == RUN) & bus.en & ~bus.stop & ~bus.go;

    clk_enable_div #(
        .PRESCALE (PRESCALE)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .clr     (div_clr),
        .en      (div_en),
        .step_en (step_en)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next datapath values; stop beats go beats stepping.
    always_comb begin
        logic tick_wrap;
        state_nxt = state;
        count_nxt = count;
        tcnt_nxt  = tcnt;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;
        tick_wrap = (tcnt == TW'(TICK_DIV - 1));
        if (bus.stop) begin
            state_nxt = IDLE;
        end else if (bus.go) begin
            state_nxt = RUN;
            count_nxt = '0;
            tcnt_nxt  = '0;
        end else if (step_en) begin
            tick_nxt = tick_wrap;
            tcnt_nxt = tick_wrap ? '0 : tcnt + TW'(1);
            if (count != WIDTH'(MAXCOUNT)) begin
                count_nxt = count + WIDTH'(1);
            end else begin
                done_nxt = 1'b1;
                if (bus.mode == MODE_ONESHOT) begin
                    state_nxt = DONE;
                end else begin
                    count_nxt = '0;
                    tcnt_nxt  = '0;
                end
            end
        end
    end

    // Registered outputs; busy tracks the state it is registered with.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tcnt  <= '0;
            tick  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            count <= count_nxt;
            tcnt  <= tcnt_nxt;
            tick  <= tick_nxt;
            done  <= done_nxt;
            busy  <= (state_nxt == RUN);
        end
    end

    assign bus.count = count;
    assign bus.tick  = tick;
    assign bus.done  = done;
    assign bus.busy  = busy;
endmodule
